// File: rtl/blur_window_engine.sv
// Separable binomial blur over a sliding KERNEL-row window: a serial horizontal pass
// fills the newest row buffer, then a serial vertical pass builds one output row.
//
// state   | meaning
// S_LOAD  | waiting for an input row (in_ready)
// S_HPASS | horizontal filter, one column per cycle into newest hbuf row
// S_VPASS | vertical filter over the hbuf rows, one column per cycle
// S_OUT   | output row held until out_ready
module blur_window_engine #(
  parameter int PIXEL_BITS = 8,
  parameter int WIN_COLS   = 16,
  parameter int KERNEL     = 5
) (
  input  logic                                    i_clk,
  input  logic                                    i_n_rst,
  input  logic                                    i_frame_start,
  input  logic                                    i_mode,
  input  logic                                    i_in_valid,
  output logic                                    o_in_ready,
  input  logic [(WIN_COLS+KERNEL-1)*PIXEL_BITS-1:0] i_in_row,
  output logic                                    o_out_valid,
  input  logic                                    i_out_ready,
  output logic [WIN_COLS*PIXEL_BITS-1:0]          o_out_row,
  output logic                                    o_busy
);
  localparam int IN_PIX = WIN_COLS + KERNEL - 1;
  localparam int SHIFT  = (KERNEL == 5) ? 4 : 2;
  localparam int ACC_W  = PIXEL_BITS + SHIFT;
  localparam int COL_W  = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
  localparam int FILL_W = $clog2(KERNEL + 1);
  localparam int CTR    = KERNEL / 2;

  if (!(KERNEL == 3 || KERNEL == 5)) begin : g_bad_kernel
    $error("blur_window_engine: KERNEL must be 3 or 5");
  end

  typedef enum logic [1:0] {S_LOAD, S_HPASS, S_VPASS, S_OUT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [FILL_W-1:0]         r_filled;
  logic [COL_W-1:0]          r_col;
  logic                      r_mode;
  logic [IN_PIX*PIXEL_BITS-1:0] r_in_row;
  logic [PIXEL_BITS-1:0]     r_hbuf [KERNEL][WIN_COLS];
  logic [PIXEL_BITS-1:0]     r_out_pix [WIN_COLS];

  logic [PIXEL_BITS-1:0]     w_in_pix [IN_PIX];
  logic [PIXEL_BITS-1:0]     w_hwin [KERNEL];
  logic [PIXEL_BITS-1:0]     w_vwin [KERNEL];
  logic [ACC_W-1:0]          w_hacc, w_vacc;
  logic [PIXEL_BITS-1:0]     w_h, w_v;
  logic                      w_last;

  function automatic logic [ACC_W-1:0] wt(input int k);
    if (KERNEL == 3) return (k == 1) ? ACC_W'(2) : ACC_W'(1);
    case (k)
      1, 3:    return ACC_W'(4);
      2:       return ACC_W'(6);
      default: return ACC_W'(1);
    endcase
  endfunction

  for (genvar i = 0; i < IN_PIX; i++) begin : g_unpack
    assign w_in_pix[i] = r_in_row[i*PIXEL_BITS +: PIXEL_BITS];
  end

  for (genvar c = 0; c < WIN_COLS; c++) begin : g_pack
    assign o_out_row[c*PIXEL_BITS +: PIXEL_BITS] = r_out_pix[c];
  end

  assign w_last      = (r_col == COL_W'(WIN_COLS - 1));
  assign o_in_ready  = (r_state == S_LOAD);
  assign o_out_valid = (r_state == S_OUT);
  assign o_busy      = (r_state != S_LOAD);

  // Select the taps for the current column once, so only KERNEL multipliers per pass.
  always_comb begin
    for (int k = 0; k < KERNEL; k++) begin
      w_hwin[k] = '0;
      w_vwin[k] = '0;
    end
    for (int c = 0; c < WIN_COLS; c++) begin
      if (r_col == COL_W'(c)) begin
        for (int k = 0; k < KERNEL; k++) begin
          w_hwin[k] = w_in_pix[c+k];
          w_vwin[k] = r_hbuf[k][c];
        end
      end
    end
  end

  always_comb begin
    w_hacc = ACC_W'(1 << (SHIFT - 1));
    w_vacc = ACC_W'(1 << (SHIFT - 1));
    for (int k = 0; k < KERNEL; k++) begin
      w_hacc = w_hacc + wt(k) * ACC_W'(w_hwin[k]);
      w_vacc = w_vacc + wt(k) * ACC_W'(w_vwin[k]);
    end
    w_h = r_mode ? PIXEL_BITS'(w_hacc >> SHIFT) : w_hwin[CTR];
    w_v = r_mode ? PIXEL_BITS'(w_vacc >> SHIFT) : w_vwin[CTR];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (i_in_valid) w_state_nxt = S_HPASS;
      S_HPASS: if (w_last) w_state_nxt = (r_filled == FILL_W'(KERNEL)) ? S_VPASS : S_LOAD;
      S_VPASS: if (w_last) w_state_nxt = S_OUT;
      S_OUT:   if (i_out_ready) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
    if (i_frame_start) w_state_nxt = S_LOAD;
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) r_state <= S_LOAD;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_filled <= '0;
      r_col    <= '0;
      r_mode   <= 1'b1;
      r_in_row <= '0;
      for (int r = 0; r < KERNEL; r++)
        for (int c = 0; c < WIN_COLS; c++) r_hbuf[r][c] <= '0;
      for (int c = 0; c < WIN_COLS; c++) r_out_pix[c] <= '0;
    end else if (i_frame_start) begin
      r_filled <= '0;
      r_col    <= '0;
      r_mode   <= i_mode;
    end else begin
      case (r_state)
        S_LOAD: if (i_in_valid) begin
          r_in_row <= i_in_row;
          r_col    <= '0;
          for (int r = 0; r < KERNEL - 1; r++)
            for (int c = 0; c < WIN_COLS; c++) r_hbuf[r][c] <= r_hbuf[r+1][c];
          if (r_filled != FILL_W'(KERNEL)) r_filled <= r_filled + 1'b1;
        end
        S_HPASS: begin
          r_hbuf[KERNEL-1][r_col] <= w_h;
          r_col <= w_last ? '0 : r_col + 1'b1;
        end
        S_VPASS: begin
          r_out_pix[r_col] <= w_v;
          r_col <= w_last ? '0 : r_col + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_window_engine.sv
// Directed bench for blur_window_engine (K=5, 16 columns, 8-bit pixels) with
// hand-computed expected rows, latency and handshake behaviour.
module tb_blur_window_engine;
  localparam int PB    = 8;
  localparam int WC    = 16;
  localparam int K     = 5;
  localparam int IN_W  = (WC + K - 1) * PB;
  localparam int OUT_W = WC * PB;

  logic             clk = 1'b0;
  logic             n_rst, fs, mode, in_valid, out_ready;
  logic [IN_W-1:0]  in_row;
  logic             in_ready, out_valid, busy;
  logic [OUT_W-1:0] out_row;

  blur_window_engine #(.PIXEL_BITS(PB), .WIN_COLS(WC), .KERNEL(K)) dut (
    .i_clk(clk), .i_n_rst(n_rst), .i_frame_start(fs), .i_mode(mode),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_row(in_row),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_row(out_row),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  int n_ov    = 0;
  int t_acc   = 0;
  logic [OUT_W-1:0] q_out [$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_ov++;
      if (out_ready) q_out.push_back(out_row);
    end
  end

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] in_uni(input logic [PB-1:0] v);
    logic [IN_W-1:0] r;
    for (int i = 0; i < WC + K - 1; i++) r[i*PB +: PB] = v;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] out_uni(input logic [PB-1:0] v);
    logic [OUT_W-1:0] r;
    for (int i = 0; i < WC; i++) r[i*PB +: PB] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic m);
    mode = m;
    fs   = 1'b1;
    tick();
    fs   = 1'b0;
  endtask

  task automatic send_row(input logic [IN_W-1:0] row);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_wait", OUT_W'(in_ready), OUT_W'(1));
    t_acc    = cyc;
    in_row   = row;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("out_valid_seen", OUT_W'(out_valid), OUT_W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0]  row;
    logic [OUT_W-1:0] exp, held;
    int base;

    n_rst = 1'b0; fs = 1'b0; mode = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    chk("rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
    chk("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("rst_busy",      OUT_W'(busy),      OUT_W'(0));
    chk("rst_out_row",   out_row,           '0);

    // 1: flat rows of 100, warm-up then one output at accept+33
    frame(1'b1);
    q_out.delete();
    for (int r = 0; r < 5; r++) send_row(in_uni(8'd100));
    wait_ov();
    chk("t1_latency", OUT_W'(cyc - t_acc), OUT_W'(33));
    chk("t1_row",     out_row,             out_uni(8'd100));
    repeat (3) tick();
    chk("t1_count",   OUT_W'(q_out.size()), OUT_W'(1));

    // 2: impulse at row 2, pixel 4
    frame(1'b1);
    for (int r = 0; r < 5; r++) begin
      row = '0;
      if (r == 2) row[4*PB +: PB] = 8'd255;
      send_row(row);
    end
    wait_ov();
    exp = '0;
    exp[0*PB +: PB] = 8'd6;
    exp[1*PB +: PB] = 8'd24;
    exp[2*PB +: PB] = 8'd36;
    exp[3*PB +: PB] = 8'd24;
    exp[4*PB +: PB] = 8'd6;
    chk("t2_impulse", out_row, exp);

    // 3: bypass, rows of 10*r; a mode flip without frame_start must be ignored
    repeat (2) tick();
    frame(1'b0);
    mode = 1'b1;
    q_out.delete();
    for (int r = 0; r < 7; r++) send_row(in_uni(PB'(10 * r)));
    repeat (40) tick();
    chk("t3_count", OUT_W'(q_out.size()), OUT_W'(3));
    chk("t3_row0",  q_out[0], out_uni(8'd20));
    chk("t3_row1",  q_out[1], out_uni(8'd30));
    chk("t3_row2",  q_out[2], out_uni(8'd40));

    // 4: backpressure on a ramp row; blur of a ramp 3*i is 3*c+6
    frame(1'b1);
    q_out.delete();
    out_ready = 1'b0;
    for (int i = 0; i < WC + K - 1; i++) row[i*PB +: PB] = PB'(3 * i);
    for (int r = 0; r < 5; r++) send_row(row);
    wait_ov();
    for (int c = 0; c < WC; c++) exp[c*PB +: PB] = PB'(3 * c + 6);
    chk("t4_ramp", out_row, exp);
    held = out_row;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stable",   out_row,             held);
      chk("t4_in_ready", OUT_W'(in_ready),    OUT_W'(0));
      chk("t4_valid",    OUT_W'(out_valid),   OUT_W'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("t4_release_ready", OUT_W'(in_ready),  OUT_W'(1));
    chk("t4_release_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("t4_count",         OUT_W'(q_out.size()), OUT_W'(1));

    // 5: frame_start during VPASS discards the window
    frame(1'b1);
    base = n_ov;
    for (int r = 0; r < 5; r++) send_row(in_uni(8'd50));
    repeat (20) tick();
    chk("t5_busy_vpass", OUT_W'(busy), OUT_W'(1));
    frame(1'b1);
    chk("t5_fs_ready", OUT_W'(in_ready),  OUT_W'(1));
    chk("t5_fs_busy",  OUT_W'(busy),      OUT_W'(0));
    chk("t5_fs_valid", OUT_W'(out_valid), OUT_W'(0));
    for (int r = 0; r < 4; r++) send_row(in_uni(8'd70));
    repeat (40) tick();
    chk("t5_no_output", OUT_W'(n_ov - base), OUT_W'(0));
    send_row(in_uni(8'd70));
    wait_ov();
    chk("t5_row", out_row, out_uni(8'd70));

    // 6: reset during HPASS, then frame_start together with in_valid
    repeat (2) tick();
    frame(1'b1);
    for (int r = 0; r < 5; r++) send_row(in_uni(8'd90));
    repeat (5) tick();
    chk("t6_busy_hpass", OUT_W'(busy), OUT_W'(1));
    base  = n_ov;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("t6_rst_ready", OUT_W'(in_ready),  OUT_W'(1));
    chk("t6_rst_busy",  OUT_W'(busy),      OUT_W'(0));
    chk("t6_rst_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("t6_rst_row",   out_row,           '0);
    fs = 1'b1; mode = 1'b1; in_valid = 1'b1; in_row = in_uni(8'd90);
    tick();
    fs = 1'b0; in_valid = 1'b0;
    chk("t6_fs_win_ready", OUT_W'(in_ready), OUT_W'(1));
    chk("t6_fs_win_busy",  OUT_W'(busy),     OUT_W'(0));
    for (int r = 0; r < 4; r++) send_row(in_uni(8'd80));
    repeat (40) tick();
    chk("t6_not_counted", OUT_W'(n_ov - base), OUT_W'(0));
    send_row(in_uni(8'd80));
    wait_ov();
    chk("t6_row", out_row, out_uni(8'd80));

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
